// File: rtl/ntt_pkg.sv
// Shared NTT constants, FSM state type and the bit-reversal helper used
// by the twiddle address path.
package ntt_pkg;

  localparam int              WIDTH = 23;
  localparam logic [WIDTH-1:0] Q    = 23'd8380417;
  localparam int              N     = 256;
  localparam int              LOGN  = 8;
  localparam int              LANES = 6;
  localparam int              NW    = (N - 1 + LANES - 1) / LANES;

  localparam logic [2:0] FORWARD_NTT_MODE = 3'd0;
  localparam logic [2:0] INVERSE_NTT_MODE = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) begin
      r[b] = v[LOGN-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_lane_addr.sv
// One lane of the twiddle index mapping: index k -> ROM address and negate
// flag. Upper-half inverse exponents fold onto ROM[N-e] with pre set.
module twiddle_lane_addr
  import ntt_pkg::*;
(
  input  logic [LOGN-1:0] k,
  input  logic            valid,
  input  logic [2:0]      mode,
  output logic [LOGN-1:0] addr,
  output logic            pre
);

  logic [LOGN-1:0] e;

  always_comb begin
    e    = bitrev(k);
    addr = '0;
    pre  = 1'b0;
    if (valid) begin
      if (mode == INVERSE_NTT_MODE) begin
        // (N - e) mod N is just the two's complement negation of e
        addr = {LOGN{1'b0}} - e;
        pre  = (e != '0);
      end else begin
        addr = e;
      end
    end
  end

endmodule

// File: rtl/twiddle_fetch.sv
// Twiddle schedule producer: issues six ROM addresses per word and delays
// the lane valids/negate mask one stage so they line up with ROM data.
module twiddle_fetch
  import ntt_pkg::*;
(
  input  logic                   ClkxCI,
  input  logic                   RstxBI,
  input  logic [2:0]             mode,
  input  logic                   StartxSI,
  input  logic                   ReadyxSI,
  output logic [LANES*LOGN-1:0]  AddrxDO,
  output logic [LANES-1:0]       pre,
  output logic [LANES-1:0]       LaneValidxDO,
  output logic                   ValidxDO,
  output logic                   BusyxSO,
  output logic                   DonexSO
);

  localparam int             WCW       = $clog2(NW);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NW - 1);

  state_t                 state;
  logic [2:0]             mode_reg;
  logic [WCW-1:0]         wcnt;
  logic                   a_valid;
  logic [LANES-1:0]       a_mask;
  logic [LANES-1:0]       a_pre;

  logic [LOGN-1:0]        lane_k [LANES];
  logic [LANES-1:0]       lane_v;
  logic [LANES-1:0]       lane_pre;
  logic [LANES*LOGN-1:0]  addr_next;
  logic                   en;
  logic                   start_ok;

  assign en       = ReadyxSI | ~ValidxDO;
  assign start_ok = StartxSI &
                    ((mode == FORWARD_NTT_MODE) | (mode == INVERSE_NTT_MODE));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      int k_full;

      // Signed index so tail lanes of the last inverse word go below 1
      always_comb begin
        if (mode_reg == INVERSE_NTT_MODE) k_full = N - 1 - LANES * int'(wcnt) - gi;
        else                              k_full = 1 + LANES * int'(wcnt) + gi;
      end

      assign lane_k[gi] = k_full[LOGN-1:0];
      assign lane_v[gi] = (k_full >= 1) && (k_full <= N - 1);

      twiddle_lane_addr u_lane (
        .k     (lane_k[gi]),
        .valid (lane_v[gi]),
        .mode  (mode_reg),
        .addr  (addr_next[gi*LOGN +: LOGN]),
        .pre   (lane_pre[gi])
      );
    end
  endgenerate

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state        <= ST_IDLE;
      mode_reg     <= '0;
      wcnt         <= '0;
      a_valid      <= 1'b0;
      a_mask       <= '0;
      a_pre        <= '0;
      AddrxDO      <= '0;
      pre          <= '0;
      LaneValidxDO <= '0;
      ValidxDO     <= 1'b0;
      BusyxSO      <= 1'b0;
      DonexSO      <= 1'b0;
    end else begin
      DonexSO <= 1'b0;

      // Both stages move together; a stall freezes the address so the ROM
      // keeps presenting the same read.
      if (en) begin
        ValidxDO     <= a_valid;
        LaneValidxDO <= a_mask;
        pre          <= a_pre;
        if (state == ST_RUN) begin
          AddrxDO <= addr_next;
          a_valid <= 1'b1;
          a_mask  <= lane_v;
          a_pre   <= lane_pre;
          wcnt    <= wcnt + 1'b1;
          if (wcnt == LAST_WORD) state <= ST_DRAIN;
        end else begin
          AddrxDO <= '0;
          a_valid <= 1'b0;
          a_mask  <= '0;
          a_pre   <= '0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            mode_reg <= mode;
            wcnt     <= '0;
            BusyxSO  <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Stage A empty and stage B handing over: the last word is taken
          if (!a_valid && ValidxDO && ReadyxSI) begin
            state   <= ST_DONE;
            DonexSO <= 1'b1;
            BusyxSO <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_fetch.sv
// Directed bench for twiddle_fetch: full forward/inverse passes, stall,
// ignored starts, mid-pass reset and back-to-back passes.
module tb_twiddle_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [47:0] addr;
  logic [5:0]  pre;
  logic [5:0]  lv;
  logic        valid;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [47:0] FWD_W0   = 48'h60A020C04080;
  localparam logic [47:0] FWD_LAST = 48'h000000FF7FBF;
  localparam logic [47:0] INV_W0   = 48'hA121C1418101;
  localparam logic [47:0] INV_LAST = 48'h00000080C040;

  always #5 clk = ~clk;

  twiddle_fetch dut (
    .ClkxCI       (clk),
    .RstxBI       (rst_n),
    .mode         (mode),
    .StartxSI     (start),
    .ReadyxSI     (ready),
    .AddrxDO      (addr),
    .pre          (pre),
    .LaneValidxDO (lv),
    .ValidxDO     (valid),
    .BusyxSO      (busy),
    .DonexSO      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] brv8(input logic [7:0] v);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[7-b];
    return r;
  endfunction

  function automatic void exp_word(input logic inv, input int j,
                                   output logic [47:0] a, output logic [5:0] p,
                                   output logic [5:0] m);
    a = '0;
    p = '0;
    m = '0;
    for (int i = 0; i < 6; i++) begin
      int         k;
      logic [7:0] e;
      k = inv ? (255 - 6 * j - i) : (1 + 6 * j + i);
      if (k >= 1 && k <= 255) begin
        e    = brv8(8'(k));
        m[i] = 1'b1;
        if (inv) begin
          a[i*8 +: 8] = 8'(256 - int'(e));
          p[i]        = (e != 8'd0);
        end else begin
          a[i*8 +: 8] = e;
        end
      end
    end
  endfunction

  // One pass from start to the Done sample; returns with the bench sitting on
  // the Done cycle so the caller can probe what follows.
  task automatic run_pass(input logic [2:0] m, input int stall_word,
                          input logic [2:0] inj_mode, input int exp_done);
    logic        inv;
    logic [47:0] a_prev, b_addr, snap_a, ea, w0, wl;
    logic [5:0]  snap_p, ep, em;
    logic        v_prev, r_prev, busy_ok, stalled;
    int          n_acc, stall_left, done_c;
    inv = (m == 3'd1);
    w0  = inv ? INV_W0 : FWD_W0;
    wl  = inv ? INV_LAST : FWD_LAST;
    ready = 1'b1;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 48'(busy), 48'd1);
    a_prev = addr; v_prev = valid; r_prev = ready; b_addr = '0;
    snap_a = '0; snap_p = '0;
    n_acc = 0; stall_left = 0; stalled = 1'b0; busy_ok = 1'b1; done_c = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 10) begin
        start = 1'b1;
        mode  = inj_mode;
      end else begin
        start = 1'b0;
      end
      if (r_prev || !v_prev) b_addr = a_prev;
      if (done) begin
        done_c = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (c == 1) begin
        chk("lat_addr_w0", addr, w0);
        chk("lat_valid_low", 48'(valid), 48'd0);
      end
      if (stall_left > 0) begin
        chk("stall_addr_hold", addr, snap_a);
        chk("stall_pre_hold", 48'(pre), 48'(snap_p));
        chk("stall_valid_hold", 48'(valid), 48'd1);
        stall_left--;
        ready = (stall_left == 0);
      end else if (!stalled && valid && n_acc == stall_word) begin
        snap_a = addr;
        snap_p = pre;
        ready = 1'b0;
        stall_left = 3;
        stalled = 1'b1;
      end
      if (valid && ready) begin
        exp_word(inv, n_acc, ea, ep, em);
        chk("word_addr", b_addr, ea);
        chk("word_pre", 48'(pre), 48'(ep));
        chk("word_lanevalid", 48'(lv), 48'(em));
        if (n_acc == 0) begin
          chk("w0_addr_hand", b_addr, w0);
          chk("w0_pre_hand", 48'(pre), inv ? 48'h3F : 48'h0);
          chk("w0_lv_hand", 48'(lv), 48'h3F);
        end
        if (n_acc == 42) begin
          chk("last_addr_hand", b_addr, wl);
          chk("last_pre_hand", 48'(pre), inv ? 48'h07 : 48'h0);
          chk("last_lv_hand", 48'(lv), 48'h07);
        end
        n_acc++;
      end
      a_prev = addr; v_prev = valid; r_prev = ready;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("done_cycle", 48'(done_c), 48'(exp_done));
    chk("words_accepted", 48'(n_acc), 48'd43);
    chk("busy_held", 48'(busy_ok), 48'd1);
    chk("busy_low_at_done", 48'(busy), 48'd0);
    chk("valid_low_at_done", 48'(valid), 48'd0);
  endtask

  initial begin
    logic [47:0] ea;
    logic [5:0]  ep, em;

    // Reset state
    #12;
    chk("rst_addr", addr, 48'd0);
    chk("rst_valid", 48'(valid), 48'd0);
    chk("rst_busy_done", 48'({busy, done}), 48'd0);
    chk("rst_pre_lv", 48'({pre, lv}), 48'd0);
    #1 rst_n = 1'b1;
    tick();

    // Unsupported mode is ignored
    mode  = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("badmode_busy", 48'(busy), 48'd0);
    tick();
    chk("badmode_addr", addr, 48'd0);
    chk("badmode_valid", 48'(valid), 48'd0);

    // Forward pass; mid-pass start with mode 2 must not disturb it
    run_pass(3'd0, -1, 3'd2, 45);

    // Start during the Done cycle is ignored, the following cycle is taken
    mode  = 3'd1;
    start = 1'b1;
    tick();
    chk("b2b_start_ignored", 48'(busy), 48'd0);
    chk("done_single_pulse", 48'(done), 48'd0);
    run_pass(3'd1, -1, 3'd0, 45);

    // Forward pass with a 3-cycle stall on word 5
    repeat (3) tick();
    run_pass(3'd0, 5, 3'd1, 48);

    // Asynchronous reset at word 20
    repeat (3) tick();
    mode  = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    exp_word(1'b0, 20, ea, ep, em);
    chk("pre_reset_addr_w20", addr, ea);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", addr, 48'd0);
    chk("async_rst_valid", 48'(valid), 48'd0);
    chk("async_rst_busy", 48'(busy), 48'd0);
    chk("async_rst_pre_lv", 48'({pre, lv}), 48'd0);
    repeat (2) tick();
    chk("rst_no_done", 48'(done), 48'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 48'({busy, valid, done}), 48'd0);
    run_pass(3'd0, -1, 3'd0, 45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
